multicycle_ctrl: RTL and testbench

- Multicycle control FSM for the 32-bit MIPS-style CPU; sequences one shared ALU and one shared instruction/data memory port across fetch, decode, execute, memory and writeback steps.
- Drives the datapath muxes and enables, and waits on a memory ready handshake.
- Uses the existing opcode map, so it replaces the single-cycle main decoder when the core is built multicycle.

---
 rtl/multicycle_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/writeback over one shared ALU and memory port.
// Optional macro MULTICYCLE_CTRL_TRAP_EN makes illegal opcodes trap and adds the illegal_op output.
module multicycle_ctrl #(
  parameter int unsigned WAIT_W  = 8,
  parameter int unsigned TIMEOUT = 200
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       pcwrite,
  output logic [1:0] pcsrc,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic       regwrite,
  output logic [1:0] regdst,
  output logic [1:0] memtoreg,
  output logic       mem_timeout,
  output logic [3:0] state
`ifdef MULTICYCLE_CTRL_TRAP_EN
  ,
  output logic       illegal_op
`endif
);

  localparam int unsigned OP_W    = 6;
  localparam int unsigned STATE_W = 4;

  localparam logic [OP_W-1:0] OP_RTYPE   = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW      = 6'b000001;
  localparam logic [OP_W-1:0] OP_SW      = 6'b000010;
  localparam logic [OP_W-1:0] OP_IMM_ADD = 6'b000011;
  localparam logic [OP_W-1:0] OP_IMM_SUB = 6'b000100;
  localparam logic [OP_W-1:0] OP_BEQ     = 6'b000101;
  localparam logic [OP_W-1:0] OP_BNE     = 6'b001001;
  localparam logic [OP_W-1:0] OP_J       = 6'b000111;
  localparam logic [OP_W-1:0] OP_JAL     = 6'b001000;
  localparam logic [OP_W-1:0] FN_JR      = 6'b000111;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_ALUWB   = 4'd7,
    S_IMMEX   = 4'd8,
    S_IMMWB   = 4'd9,
    S_BRANCH  = 4'd10,
    S_JUMP    = 4'd11,
    S_JAL     = 4'd12,
    S_JR      = 4'd13,
    S_ILLEGAL = 4'd14
  } state_e;

  state_e            r_state;
  state_e            w_next;
  logic [WAIT_W-1:0] r_wait;
  logic              w_wait_st;
  logic              w_abort;

  // Stall accounting: only the three memory-access states can time out; ready always wins.
  assign w_wait_st = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
  assign w_abort   = w_wait_st && !mem_ready && (r_wait == WAIT_W'(TIMEOUT));
  assign state     = r_state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wait <= '0;
    end else if ((w_next != r_state) || w_abort) begin
      r_wait <= '0;
    end else if (w_wait_st && !mem_ready) begin
      r_wait <= r_wait + WAIT_W'(1);
    end
  end

  // Next state and datapath controls; everything is held low while reset is asserted.
  always_comb begin
    w_next      = r_state;
    mem_req     = 1'b0;
    iord        = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    pcwrite     = 1'b0;
    pcsrc       = 2'b00;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    aluop       = 2'b00;
    regwrite    = 1'b0;
    regdst      = 2'b00;
    memtoreg    = 2'b00;
    mem_timeout = 1'b0;
`ifdef MULTICYCLE_CTRL_TRAP_EN
    illegal_op  = 1'b0;
`endif
    if (reset_n) begin
      mem_timeout = w_abort;
      case (r_state)
        S_FETCH: begin
          mem_req = 1'b1;
          alusrcb = 2'b01;
          if (mem_ready) begin
            irwrite = 1'b1;
            pcwrite = 1'b1;
            w_next  = S_DECODE;
          end else if (w_abort) begin
            w_next  = S_FETCH;
          end
        end
        S_DECODE: begin
          alusrcb = 2'b11;
          case (op)
            OP_RTYPE:            w_next = (funct == FN_JR) ? S_JR : S_EXEC;
            OP_LW, OP_SW:        w_next = S_MEMADR;
            OP_IMM_ADD,
            OP_IMM_SUB:          w_next = S_IMMEX;
            OP_BEQ, OP_BNE:      w_next = S_BRANCH;
            OP_J:                w_next = S_JUMP;
            OP_JAL:              w_next = S_JAL;
            default:             w_next = S_ILLEGAL;
          endcase
        end
        S_MEMADR: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
          w_next  = (op == OP_LW) ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          if (mem_ready) begin
            w_next = S_MEMWB;
          end else if (w_abort) begin
            w_next = S_FETCH;
          end
        end
        S_MEMWB: begin
          regwrite = 1'b1;
          memtoreg = 2'b01;
          w_next   = S_FETCH;
        end
        S_MEMWR: begin
          mem_req  = 1'b1;
          iord     = 1'b1;
          memwrite = !w_abort;
          if (mem_ready || w_abort) begin
            w_next = S_FETCH;
          end
        end
        S_EXEC: begin
          alusrca = 1'b1;
          aluop   = 2'b10;
          w_next  = S_ALUWB;
        end
        S_ALUWB: begin
          regwrite = 1'b1;
          regdst   = 2'b01;
          w_next   = S_FETCH;
        end
        S_IMMEX: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
          aluop   = (op == OP_IMM_SUB) ? 2'b01 : 2'b00;
          w_next  = S_IMMWB;
        end
        S_IMMWB: begin
          regwrite = 1'b1;
          w_next   = S_FETCH;
        end
        S_BRANCH: begin
          alusrca = 1'b1;
          aluop   = 2'b01;
          pcsrc   = 2'b01;
          pcwrite = (op == OP_BNE) ? !zero : zero;
          w_next  = S_FETCH;
        end
        S_JUMP: begin
          pcsrc   = 2'b10;
          pcwrite = 1'b1;
          w_next  = S_FETCH;
        end
        S_JAL: begin
          // PC register still holds PC+4 here, so the link value comes straight from it.
          pcsrc    = 2'b10;
          pcwrite  = 1'b1;
          regwrite = 1'b1;
          regdst   = 2'b10;
          memtoreg = 2'b10;
          w_next   = S_FETCH;
        end
        S_JR: begin
          pcsrc   = 2'b11;
          pcwrite = 1'b1;
          w_next  = S_FETCH;
        end
        S_ILLEGAL: begin
`ifdef MULTICYCLE_CTRL_TRAP_EN
          illegal_op = 1'b1;
          w_next     = S_ILLEGAL;
`else
          w_next     = S_FETCH;
`endif
        end
        default: begin
          w_next = S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-instruction expected cycle traces from a queue model, plus literal pins.
module tb_multicycle_ctrl;

  localparam int TO = 4;

  localparam logic [3:0] ST_FETCH  = 4'd0;
  localparam logic [3:0] ST_DECODE = 4'd1;
  localparam logic [3:0] ST_MEMADR = 4'd2;
  localparam logic [3:0] ST_MEMRD  = 4'd3;
  localparam logic [3:0] ST_MEMWB  = 4'd4;
  localparam logic [3:0] ST_MEMWR  = 4'd5;
  localparam logic [3:0] ST_EXEC   = 4'd6;
  localparam logic [3:0] ST_ALUWB  = 4'd7;
  localparam logic [3:0] ST_IMMEX  = 4'd8;
  localparam logic [3:0] ST_IMMWB  = 4'd9;
  localparam logic [3:0] ST_BRANCH = 4'd10;
  localparam logic [3:0] ST_JUMP   = 4'd11;
  localparam logic [3:0] ST_JAL    = 4'd12;
  localparam logic [3:0] ST_JR     = 4'd13;
  localparam logic [3:0] ST_ILL    = 4'd14;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b000001;
  localparam logic [5:0] OP_SW   = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b000011;
  localparam logic [5:0] OP_SUBI = 6'b000100;
  localparam logic [5:0] OP_BEQ  = 6'b000101;
  localparam logic [5:0] OP_BNE  = 6'b001001;
  localparam logic [5:0] OP_J    = 6'b000111;
  localparam logic [5:0] OP_JAL  = 6'b001000;
  localparam logic [5:0] FN_JR   = 6'b000111;

  typedef struct packed {
    logic [3:0] st;
    logic       req;
    logic       iord;
    logic       mw;
    logic       irw;
    logic       pcw;
    logic [1:0] pcsrc;
    logic       asa;
    logic [1:0] asb;
    logic [1:0] aop;
    logic       rw;
    logic [1:0] rdst;
    logic [1:0] m2r;
    logic       tmo;
    logic       ill;
  } ctl_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, iord, memwrite, irwrite, pcwrite, alusrca, regwrite, mem_timeout;
  logic [1:0] pcsrc, alusrcb, aluop, regdst, memtoreg;
  logic [3:0] state;
`ifdef MULTICYCLE_CTRL_TRAP_EN
  logic       illegal_op;
`endif

  ctl_t act;
  ctl_t cmp_e;
  ctl_t exp_q[$];
  ctl_t alog[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc_n  = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.WAIT_W(8), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .pcwrite(pcwrite),
    .pcsrc(pcsrc), .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop), .regwrite(regwrite),
    .regdst(regdst), .memtoreg(memtoreg), .mem_timeout(mem_timeout), .state(state)
`ifdef MULTICYCLE_CTRL_TRAP_EN
    , .illegal_op(illegal_op)
`endif
  );

  always_comb begin
    act       = '0;
    act.st    = state;
    act.req   = mem_req;
    act.iord  = iord;
    act.mw    = memwrite;
    act.irw   = irwrite;
    act.pcw   = pcwrite;
    act.pcsrc = pcsrc;
    act.asa   = alusrca;
    act.asb   = alusrcb;
    act.aop   = aluop;
    act.rw    = regwrite;
    act.rdst  = regdst;
    act.m2r   = memtoreg;
    act.tmo   = mem_timeout;
`ifdef MULTICYCLE_CTRL_TRAP_EN
    act.ill   = illegal_op;
`endif
  end

  // Single compare process: one expected control word per cycle while the model has one queued.
  always @(negedge clk) begin
    cyc_n++;
    if (exp_q.size() > 0) begin
      cmp_e = exp_q.pop_front();
      alog.push_back(act);
      n_chk++;
      if (act !== cmp_e) begin
        n_fail++;
        $display("FAIL ctl_word cycle %0d: got st=%0d word=%h, expected st=%0d word=%h",
                 cyc_n, act.st, act, cmp_e.st, cmp_e);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  function automatic ctl_t w0(input logic [3:0] st);
    ctl_t c;
    c    = '0;
    c.st = st;
    return c;
  endfunction

  // Expected word for a memory-access cycle: done = ready this cycle, tmo = abort this cycle.
  function automatic ctl_t mem_w(input logic [3:0] st, input bit done, input bit tmo);
    ctl_t c;
    c     = w0(st);
    c.req = 1'b1;
    c.tmo = tmo;
    if (st == ST_FETCH) begin
      c.asb = 2'b01;
      c.irw = done;
      c.pcw = done;
    end else begin
      c.iord = 1'b1;
      c.mw   = (st == ST_MEMWR) && !tmo;
    end
    return c;
  endfunction

  task automatic cyc(input logic rdy, input ctl_t e);
    mem_ready = rdy;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // n_stall cycles of mem_ready=0; every (TO+1)th stall aborts. Fetch retries, data access gives up.
  task automatic access(input logic [3:0] st, input int n_stall, output bit aborted);
    aborted = 1'b0;
    for (int k = 0; k < n_stall; k++) begin
      if ((k % (TO + 1)) == TO) begin
        cyc(1'b0, mem_w(st, 1'b0, 1'b1));
        if (st != ST_FETCH) begin
          aborted = 1'b1;
          return;
        end
      end else begin
        cyc(1'b0, mem_w(st, 1'b0, 1'b0));
      end
    end
    cyc(1'b1, mem_w(st, 1'b1, 1'b0));
  endtask

  task automatic instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                       input int fst, input int mst, input logic idle);
    ctl_t c;
    bit   ab;
    op = o; funct = f; zero = z;
    access(ST_FETCH, fst, ab);
    c = w0(ST_DECODE); c.asb = 2'b11; cyc(idle, c);
    if (o == OP_R && f == FN_JR) begin
      c = w0(ST_JR); c.pcsrc = 2'b11; c.pcw = 1'b1; cyc(idle, c);
    end else if (o == OP_R) begin
      c = w0(ST_EXEC); c.asa = 1'b1; c.aop = 2'b10; cyc(idle, c);
      c = w0(ST_ALUWB); c.rw = 1'b1; c.rdst = 2'b01; cyc(idle, c);
    end else if (o == OP_LW || o == OP_SW) begin
      c = w0(ST_MEMADR); c.asa = 1'b1; c.asb = 2'b10; cyc(idle, c);
      access((o == OP_LW) ? ST_MEMRD : ST_MEMWR, mst, ab);
      if (o == OP_LW && !ab) begin
        c = w0(ST_MEMWB); c.rw = 1'b1; c.m2r = 2'b01; cyc(idle, c);
      end
    end else if (o == OP_ADDI || o == OP_SUBI) begin
      c = w0(ST_IMMEX); c.asa = 1'b1; c.asb = 2'b10;
      c.aop = (o == OP_SUBI) ? 2'b01 : 2'b00; cyc(idle, c);
      c = w0(ST_IMMWB); c.rw = 1'b1; cyc(idle, c);
    end else if (o == OP_BEQ || o == OP_BNE) begin
      c = w0(ST_BRANCH); c.asa = 1'b1; c.aop = 2'b01; c.pcsrc = 2'b01;
      c.pcw = (o == OP_BEQ) ? z : !z; cyc(idle, c);
    end else if (o == OP_J) begin
      c = w0(ST_JUMP); c.pcsrc = 2'b10; c.pcw = 1'b1; cyc(idle, c);
    end else if (o == OP_JAL) begin
      c = w0(ST_JAL); c.pcsrc = 2'b10; c.pcw = 1'b1; c.rw = 1'b1;
      c.rdst = 2'b10; c.m2r = 2'b10; cyc(idle, c);
    end else begin
`ifdef MULTICYCLE_CTRL_TRAP_EN
      c = w0(ST_ILL); c.ill = 1'b1;
      for (int i = 0; i < 4; i++) cyc(idle, c);
`else
      cyc(idle, w0(ST_ILL));
`endif
    end
  endtask

  task automatic reset_pulse();
    reset_n = 1'b0;
    #1;
    check("reset_state", 32'(state), 32'(ST_FETCH));
    check("reset_req_wr", 32'({mem_req, memwrite, irwrite, pcwrite, regwrite}), 32'd0);
`ifdef MULTICYCLE_CTRL_TRAP_EN
    check("reset_illegal_op", 32'(illegal_op), 32'd0);
`endif
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    bit ab;
    ctl_t c;
    reset_n = 1'b0; op = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 32'(state), 32'(ST_FETCH));
    check("reset_outputs", 32'(act), 32'd0);
    reset_n = 1'b1;

    // R-type, mem_ready tied high
    alog.delete();
    instr(OP_R, 6'b100000, 1'b0, 0, 0, 1'b1);
    check("rtype_len", 32'(alog.size()), 32'd4);
    check("rtype_states", 32'({alog[0].st, alog[1].st, alog[2].st, alog[3].st}), 32'h0167);
    check("rtype_aluwb_rw_rdst", 32'({alog[3].rw, alog[3].rdst}), 32'b101);
    cnt = 0;
    foreach (alog[i]) if (alog[i].rw) cnt++;
    check("rtype_rw_once", 32'(cnt), 32'd1);

    // Load with a 3-cycle stall in MEMRD
    alog.delete();
    instr(OP_LW, 6'd0, 1'b0, 0, 3, 1'b1);
    cnt = 0;
    foreach (alog[i]) if (alog[i].st == ST_MEMRD && alog[i].req) cnt++;
    check("lw_req_cycles", 32'(cnt), 32'd4);
    check("lw_memwb", 32'({alog[7].st, alog[7].rw, alog[7].m2r}), 32'b0100_1_01);
    cnt = 0;
    foreach (alog[i]) if (alog[i].tmo) cnt++;
    check("lw_no_timeout", 32'(cnt), 32'd0);

    // Branches with zero=1
    alog.delete();
    instr(OP_BEQ, 6'd0, 1'b1, 0, 0, 1'b1);
    check("beq_taken_pcw", 32'(alog[2].pcw), 32'd1);
    alog.delete();
    instr(OP_BNE, 6'd0, 1'b1, 0, 0, 1'b1);
    check("bne_not_taken_pcw", 32'(alog[2].pcw), 32'd0);
    instr(OP_BEQ, 6'd0, 1'b0, 1, 0, 1'b0);
    instr(OP_BNE, 6'd0, 1'b0, 0, 0, 1'b0);

    // Jump-and-link
    alog.delete();
    instr(OP_JAL, 6'd0, 1'b0, 0, 0, 1'b1);
    check("jal_controls", 32'({alog[2].pcsrc, alog[2].pcw, alog[2].rw, alog[2].rdst, alog[2].m2r}), 32'hBA);

    // Fetch timeout, retry, then ready exactly at the timeout count
    alog.delete();
    instr(OP_J, 6'd0, 1'b0, 2 * TO + 1, 0, 1'b1);
    cnt = 0;
    foreach (alog[i]) if (alog[i].tmo) cnt++;
    check("fetch_timeout_pulses", 32'(cnt), 32'd1);
    check("fetch_timeout_at", 32'({alog[4].st, alog[4].tmo}), 32'b0000_1);
    cnt = 0;
    for (int i = 0; i < 9; i++) if (alog[i].irw || alog[i].pcw) cnt++;
    check("fetch_timeout_no_write", 32'(cnt), 32'd0);
    check("ready_wins_at_timeout", 32'({alog[9].irw, alog[9].tmo}), 32'b10);

    // Remaining instruction classes and data-access corner cases
    instr(OP_R, FN_JR, 1'b0, 2, 0, 1'b0);
    instr(OP_ADDI, 6'd0, 1'b0, 0, 0, 1'b1);
    instr(OP_SUBI, 6'd0, 1'b1, 1, 0, 1'b0);
    instr(OP_SW, 6'd0, 1'b0, 0, 2, 1'b1);
    instr(OP_LW, 6'd0, 1'b0, 0, TO, 1'b0);
    alog.delete();
    instr(OP_SW, 6'd0, 1'b0, 0, TO + 1, 1'b1);
    check("sw_abort_write_suppressed", 32'({alog[7].st, alog[7].mw, alog[7].tmo}), 32'b0101_0_1);
    instr(OP_LW, 6'd0, 1'b0, 0, TO + 1, 1'b0);
    instr(OP_R, 6'b100010, 1'b0, 0, 0, 1'b1);

    // Asynchronous reset in the middle of a store
    op = OP_SW; funct = 6'd0; zero = 1'b0;
    access(ST_FETCH, 0, ab);
    c = w0(ST_DECODE); c.asb = 2'b11; cyc(1'b0, c);
    c = w0(ST_MEMADR); c.asa = 1'b1; c.asb = 2'b10; cyc(1'b0, c);
    cyc(1'b0, mem_w(ST_MEMWR, 1'b0, 1'b0));
    cyc(1'b0, mem_w(ST_MEMWR, 1'b0, 1'b0));
    check("memwr_before_reset", 32'({state, mem_req, memwrite}), 32'b0101_1_1);
    #2;
    reset_pulse();
    instr(OP_R, 6'b100000, 1'b0, TO, 0, 1'b1);

    // Illegal opcode
    instr(6'b111111, 6'd0, 1'b0, 0, 0, 1'b1);
`ifndef MULTICYCLE_CTRL_TRAP_EN
    instr(OP_J, 6'd0, 1'b0, 0, 0, 1'b1);
`endif
    reset_pulse();
    instr(OP_ADDI, 6'd0, 1'b0, 0, 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
